serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx.sv | 156 +++++++++++++++
 tb/tb_serial_pattern_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serializes an 8-bit word MSB first on a registered line, followed by GAP_BITS zero bits.
// Define SERIAL_PATTERN_TX_PREAMBLE_EN to prefix every frame with the preamble 1101.
module serial_pattern_tx #(
    parameter int CLK_DIV  = 1,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       bit_strobe,
    output logic       busy,
    output logic       frame_done
);

    // A divider of 0 is treated as 1 so every bit still lasts at least one clock.
    localparam int         DIV_EFF    = (CLK_DIV < 1) ? 1 : CLK_DIV;
    localparam logic [7:0] DIV_RELOAD = 8'(DIV_EFF - 1);
    localparam bit         HAS_GAP    = (GAP_BITS > 0);
    localparam logic [3:0] GAP_LAST   = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam logic [3:0] PREAMBLE_SEQ = 4'b1011;
    typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2, GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2, GAP = 2'd3} state_t;
`endif

    state_t     state, state_n;
    logic [7:0] div_cnt, div_n;
    logic [3:0] bit_cnt, bit_n;
    logic [7:0] shift_reg, shift_n;
    logic       serial_n, strobe_n, done_n, last_bit, bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 4'd0;
            shift_reg  <= 8'd0;
            serial_out <= 1'b0;
            bit_strobe <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            tx_ready   <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            shift_reg  <= shift_n;
            serial_out <= serial_n;
            bit_strobe <= strobe_n;
            frame_done <= done_n;
            busy       <= (state_n != IDLE);
            tx_ready   <= (state_n == IDLE);
        end
    end

    // Next values describe the cycle about to start, so every output is a plain flop.
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift_reg;
        serial_n = serial_out;
        strobe_n = 1'b0;
        bit_end  = (div_cnt == 8'd0);
        case (state)
            IDLE: begin
                serial_n = 1'b0;
                div_n    = 8'd0;
                bit_n    = 4'd0;
                if (tx_valid && tx_ready) begin
                    div_n    = DIV_RELOAD;
                    strobe_n = 1'b1;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
                    state_n  = PREAMBLE;
                    serial_n = PREAMBLE_SEQ[0];
                    shift_n  = tx_data;
`else
                    state_n  = DATA;
                    serial_n = tx_data[7];
                    shift_n  = {tx_data[6:0], 1'b0};
`endif
                end
            end
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            PREAMBLE: begin
                if (!bit_end) begin
                    div_n = div_cnt - 8'd1;
                end else begin
                    div_n    = DIV_RELOAD;
                    strobe_n = 1'b1;
                    if (bit_cnt == 4'd3) begin
                        state_n  = DATA;
                        bit_n    = 4'd0;
                        serial_n = shift_reg[7];
                        shift_n  = {shift_reg[6:0], 1'b0};
                    end else begin
                        bit_n    = bit_cnt + 4'd1;
                        serial_n = PREAMBLE_SEQ[bit_n[1:0]];
                    end
                end
            end
`endif
            DATA: begin
                if (!bit_end) begin
                    div_n = div_cnt - 8'd1;
                end else if (bit_cnt != 4'd7) begin
                    div_n    = DIV_RELOAD;
                    strobe_n = 1'b1;
                    bit_n    = bit_cnt + 4'd1;
                    serial_n = shift_reg[7];
                    shift_n  = {shift_reg[6:0], 1'b0};
                end else if (HAS_GAP) begin
                    state_n  = GAP;
                    div_n    = DIV_RELOAD;
                    strobe_n = 1'b1;
                    bit_n    = 4'd0;
                    serial_n = 1'b0;
                end else begin
                    state_n  = IDLE;
                    div_n    = 8'd0;
                    bit_n    = 4'd0;
                    serial_n = 1'b0;
                end
            end
            GAP: begin
                serial_n = 1'b0;
                if (!bit_end) begin
                    div_n = div_cnt - 8'd1;
                end else if (bit_cnt == GAP_LAST) begin
                    state_n = IDLE;
                    div_n   = 8'd0;
                    bit_n   = 4'd0;
                end else begin
                    div_n    = DIV_RELOAD;
                    strobe_n = 1'b1;
                    bit_n    = bit_cnt + 4'd1;
                end
            end
            default: begin
                state_n  = IDLE;
                serial_n = 1'b0;
                div_n    = 8'd0;
                bit_n    = 4'd0;
            end
        endcase
        last_bit = ((state_n == GAP) && (bit_n == GAP_LAST)) ||
                   (!HAS_GAP && (state_n == DATA) && (bit_n == 4'd7));
        done_n   = last_bit && (div_n == 8'd0);
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: four parameterizations share one stimulus stream
// and are compared cycle by cycle against a frame model built from bit timing arithmetic.
module tb_serial_pattern_tx;

    localparam int NI = 4;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [NI-1:0] rdy_v, so_v, st_v, bz_v, fd_v;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_pattern_tx #(.CLK_DIV(1), .GAP_BITS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy_v[0]), .serial_out(so_v[0]), .bit_strobe(st_v[0]),
        .busy(bz_v[0]), .frame_done(fd_v[0]));

    serial_pattern_tx #(.CLK_DIV(3), .GAP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy_v[1]), .serial_out(so_v[1]), .bit_strobe(st_v[1]),
        .busy(bz_v[1]), .frame_done(fd_v[1]));

    serial_pattern_tx #(.CLK_DIV(1), .GAP_BITS(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy_v[2]), .serial_out(so_v[2]), .bit_strobe(st_v[2]),
        .busy(bz_v[2]), .frame_done(fd_v[2]));

    serial_pattern_tx #(.CLK_DIV(0), .GAP_BITS(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy_v[3]), .serial_out(so_v[3]), .bit_strobe(st_v[3]),
        .busy(bz_v[3]), .frame_done(fd_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        case (i)
            1:       return 3;
            3:       return 1;
            default: return 1;
        endcase
    endfunction

    function automatic int gap_of(input int i);
        case (i)
            2:       return 0;
            3:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int frame_len(input int i);
        return div_of(i) * ((PRE ? 4 : 0) + 8 + gap_of(i));
    endfunction

    // Expected {tx_ready, busy, frame_done, bit_strobe, serial_out} in cycle k after acceptance.
    function automatic logic [4:0] model(input int i, input logic [7:0] w, input int k);
        int d, b, pb, len;
        logic [3:0] pat;
        logic [7:0] word;
        logic o;
        d    = div_of(i);
        pb   = PRE ? 4 : 0;
        len  = frame_len(i);
        pat  = 4'b1101;
        word = w;
        if (k < 1 || k > len) return 5'b10000;
        b = (k - 1) / d;
        if (b < pb)           o = pat[2'(3 - b)];
        else if (b - pb < 8)  o = word[3'(7 - (b - pb))];
        else                  o = 1'b0;
        return {1'b0, 1'b1, (k == len), ((k - 1) % d == 0), o};
    endfunction

    function automatic logic [4:0] observe(input int i);
        return {rdy_v[i], bz_v[i], fd_v[i], st_v[i], so_v[i]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (observe(i) !== 5'b00000) begin
                tests_failed++;
                $display("[TB] FAIL reset_state inst=%0d got=%b want=%b", i, observe(i), 5'b00000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (rdy_v[i] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL ready_before_edge inst=%0d got=%b want=0", i, rdy_v[i]);
            end
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (observe(i) !== 5'b10000) begin
                tests_failed++;
                $display("[TB] FAIL ready_after_edge inst=%0d got=%b want=%b", i, observe(i), 5'b10000);
            end
        end
        tx_valid = 1'b0;
    endtask

    // Random tx_valid/tx_data while every instance is busy must not disturb any frame.
    task automatic test_frame(input logic [7:0] w);
        int maxlen, minlen;
        maxlen = 0;
        minlen = 1 << 30;
        for (int i = 0; i < NI; i++) begin
            if (frame_len(i) > maxlen) maxlen = frame_len(i);
            if (frame_len(i) < minlen) minlen = frame_len(i);
        end
        do_reset();
        tx_valid = 1'b1;
        tx_data  = w;
        for (int k = 1; k <= maxlen + 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (observe(i) !== model(i, w, k)) begin
                    tests_failed++;
                    $display("[TB] FAIL frame word=%h inst=%0d cycle=%0d got=%b want=%b (ready,busy,done,strobe,out)",
                             w, i, k, observe(i), model(i, w, k));
                end
            end
            tx_data  = 8'($urandom);
            tx_valid = (k < minlen) ? 1'($urandom) : 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int len;
        logic [4:0] exp;
        len = frame_len(0);
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        for (int k = 1; k <= 2 * len + 2; k++) begin
            @(negedge clk);
            if (k <= len)          exp = model(0, 8'h11, k);
            else if (k == len + 1) exp = 5'b10000;
            else                   exp = model(0, 8'h22, k - len - 1);
            tests_run++;
            if (observe(0) !== exp) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cycle=%0d got=%b want=%b", k, observe(0), exp);
            end
            if (k == len + 1) begin
                tx_data = 8'h22;
            end else begin
                tx_data = 8'($urandom);
                if (k > len + 1) tx_valid = 1'b0;
            end
        end
    endtask

    task automatic test_mid_reset();
        int pb;
        pb = PRE ? 4 : 0;
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int k = 1; k <= pb + 4; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        tests_run++;
        if ({bz_v[0], so_v[0]} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL mid_frame_active got=%b want=11", {bz_v[0], so_v[0]});
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (observe(i) !== 5'b00000) begin
                tests_failed++;
                $display("[TB] FAIL mid_reset_async inst=%0d got=%b want=%b", i, observe(i), 5'b00000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (observe(i) !== 5'b10000) begin
                    tests_failed++;
                    $display("[TB] FAIL after_abort inst=%0d cycle=%0d got=%b want=%b", i, k, observe(i), 5'b10000);
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_frame(8'hA5);
        test_frame(8'h0F);
        test_frame(8'h80);
        test_frame(8'h01);
        for (int n = 0; n < 6; n++) test_frame(8'($urandom));
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
